// File: rtl/fb_pkg.sv
// Shared types and defaults for the rectangle framebuffer writer.
package fb_pkg;

    localparam int FB_DEFAULT_WIDTH  = 320;
    localparam int FB_DEFAULT_HEIGHT = 180;

    typedef enum logic [1:0] {
        OP_FILL  = 2'd0,
        OP_CLEAR = 2'd1,
        OP_SWAP  = 2'd2,
        OP_NOP   = 2'd3
    } fb_op_t;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_SWAP = 2'd2
    } fb_state_t;

endpackage

// File: rtl/fb_rect_writer_if.sv
// Framebuffer write bus: the writer drives pixels and buffer swaps, the memory side may drive debug_read.
interface frame_buffer_bus #(
    parameter int ADDR_W = 16
);
    logic [15:0]       write_data;
    logic [ADDR_W-1:0] write_addr;
    logic              write_enable;
    logic              write_clk;
    logic              swap_buffer;
    logic [15:0]       debug_read;

    modport WRITE (
        output write_data,
        output write_addr,
        output write_enable,
        output write_clk,
        output swap_buffer
    );

    modport READ (
        input  write_data,
        input  write_addr,
        input  write_enable,
        input  write_clk,
        input  swap_buffer,
        output debug_read
    );
endinterface

// File: rtl/fb_rect_clip.sv
// Combinational clip of a rectangle against the framebuffer; x1/y1 are exclusive bounds.
module fb_rect_clip #(
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 180
) (
    input  logic [8:0] x,
    input  logic [7:0] y,
    input  logic [8:0] w,
    input  logic [7:0] h,
    output logic [8:0] x0,
    output logic [7:0] y0,
    output logic [9:0] x1,
    output logic [8:0] y1,
    output logic       empty
);
    localparam logic [9:0] W_L = 10'(FB_WIDTH);
    localparam logic [8:0] H_L = 9'(FB_HEIGHT);

    logic [9:0] x_sum;
    logic [8:0] y_sum;

    // Sums are one bit wider so x+w / y+h never wrap before the clamp.
    always_comb begin
        x_sum = {1'b0, x} + {1'b0, w};
        y_sum = {1'b0, y} + {1'b0, h};
        x0    = x;
        y0    = y;
        x1    = (x_sum > W_L) ? W_L : x_sum;
        y1    = (y_sum > H_L) ? H_L : y_sum;
        empty = (w == 9'd0) || (h == 8'd0) ||
                ({1'b0, x} >= W_L) || ({1'b0, y} >= H_L);
    end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle fill/clear/swap engine driving a framebuffer write bus.
// Optional pixel counter enabled by defining FB_WRITER_PIXEL_COUNT_EN.
module fb_rect_writer
    import fb_pkg::*;
#(
    parameter  int FB_WIDTH  = FB_DEFAULT_WIDTH,
    parameter  int FB_HEIGHT = FB_DEFAULT_HEIGHT,
    localparam int FB_SIZE   = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    // A command transfers on a rising edge where cmd_valid && cmd_ready; cmd_* are don't-care otherwise.
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  fb_op_t               cmd_op,
    input  logic [8:0]           cmd_x,
    input  logic [7:0]           cmd_y,
    input  logic [8:0]           cmd_w,
    input  logic [7:0]           cmd_h,
    input  rgb565_t              cmd_color,
    output logic                 busy,
    frame_buffer_bus.WRITE       bus,
    output fb_state_t            state_dbg
`ifdef FB_WRITER_PIXEL_COUNT_EN
    ,
    output logic [31:0]          pixel_count
`endif
);
    localparam logic [FB_SIZE-1:0] W_A = FB_SIZE'(FB_WIDTH);

    fb_state_t          state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               we_q, we_d;
    logic               swap_q, swap_d;
    logic [FB_SIZE-1:0] addr_q, addr_d;
    rgb565_t            data_q, data_d;
    logic [8:0]         cur_x_q, cur_x_d;
    logic [7:0]         cur_y_q, cur_y_d;
    logic [8:0]         x0_q, x0_d;
    logic [9:0]         x1_q, x1_d;
    logic [8:0]         y1_q, y1_d;
    logic [FB_SIZE-1:0] row_base_q, row_base_d;

    logic [8:0] clip_in_x, clip_in_w;
    logic [7:0] clip_in_y, clip_in_h;
    logic [8:0] clip_x0;
    logic [7:0] clip_y0;
    logic [9:0] clip_x1;
    logic [8:0] clip_y1;
    logic       clip_empty;
    logic       x_last, y_last;

    // A clear is simply a fill of the whole framebuffer.
    always_comb begin
        if (cmd_op == OP_CLEAR) begin
            clip_in_x = 9'd0;
            clip_in_y = 8'd0;
            clip_in_w = 9'(FB_WIDTH);
            clip_in_h = 8'(FB_HEIGHT);
        end else begin
            clip_in_x = cmd_x;
            clip_in_y = cmd_y;
            clip_in_w = cmd_w;
            clip_in_h = cmd_h;
        end
    end

    fb_rect_clip #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT)
    ) u_clip (
        .x     (clip_in_x),
        .y     (clip_in_y),
        .w     (clip_in_w),
        .h     (clip_in_h),
        .x0    (clip_x0),
        .y0    (clip_y0),
        .x1    (clip_x1),
        .y1    (clip_y1),
        .empty (clip_empty)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = 1'b0;
        swap_d     = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        row_base_d = row_base_q;
        x_last     = (({1'b0, cur_x_q} + 10'd1) == x1_q);
        y_last     = (({1'b0, cur_y_q} + 9'd1) == y1_q);

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_FILL, OP_CLEAR: begin
                            if (!clip_empty) begin
                                state_d    = ST_DRAW;
                                we_d       = 1'b1;
                                cur_x_d    = clip_x0;
                                cur_y_d    = clip_y0;
                                x0_d       = clip_x0;
                                x1_d       = clip_x1;
                                y1_d       = clip_y1;
                                // Constant-coefficient product, only for the first row base.
                                row_base_d = FB_SIZE'(clip_y0) * W_A;
                                addr_d     = row_base_d + FB_SIZE'(clip_x0);
                                data_d     = cmd_color;
                            end
                        end
                        OP_SWAP: begin
                            state_d = ST_SWAP;
                            swap_d  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_DRAW: begin
                if (x_last && y_last) begin
                    state_d = ST_IDLE;
                end else if (x_last) begin
                    we_d       = 1'b1;
                    cur_x_d    = x0_q;
                    cur_y_d    = cur_y_q + 8'd1;
                    row_base_d = row_base_q + W_A;
                    addr_d     = row_base_q + W_A + FB_SIZE'(x0_q);
                end else begin
                    we_d    = 1'b1;
                    cur_x_d = cur_x_q + 9'd1;
                    addr_d  = addr_q + FB_SIZE'(1);
                end
            end
            ST_SWAP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

`ifdef FB_WRITER_PIXEL_COUNT_EN
    logic [31:0] pixel_count_q, pixel_count_d;

    always_comb begin
        pixel_count_d = we_q ? (pixel_count_q + 32'd1) : pixel_count_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) pixel_count_q <= 32'd0;
        else        pixel_count_q <= pixel_count_d;
    end

    assign pixel_count = pixel_count_q;
`else
    // No pixel counter in this build.
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            we_q        <= 1'b0;
            swap_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            row_base_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            we_q        <= we_d;
            swap_q      <= swap_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            row_base_q  <= row_base_d;
        end
    end

    assign cmd_ready        = cmd_ready_q;
    assign busy             = ~cmd_ready_q;
    assign state_dbg        = state_q;
    assign bus.write_clk    = clk_in;
    assign bus.write_enable = we_q;
    assign bus.swap_buffer  = swap_q;
    assign bus.write_addr   = addr_q;
    assign bus.write_data   = data_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer: directed corner cases plus random commands vs. a rectangle model.
module tb_fb_rect_writer;
    import fb_pkg::*;

    localparam int W  = 320;
    localparam int H  = 180;
    localparam int AW = 16;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      cmd_valid = 1'b0;
    logic      cmd_ready;
    fb_op_t    cmd_op = OP_NOP;
    logic [8:0] cmd_x = '0;
    logic [7:0] cmd_y = '0;
    logic [8:0] cmd_w = '0;
    logic [7:0] cmd_h = '0;
    rgb565_t   cmd_color = '0;
    logic      busy;
    fb_state_t state_dbg;
`ifdef FB_WRITER_PIXEL_COUNT_EN
    logic [31:0] pixel_count;
`endif

    frame_buffer_bus #(.ADDR_W(AW)) bus ();
    assign bus.debug_read = '0;

    fb_rect_writer #(
        .FB_WIDTH  (W),
        .FB_HEIGHT (H)
    ) dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .busy      (busy),
        .bus       (bus),
        .state_dbg (state_dbg)
`ifdef FB_WRITER_PIXEL_COUNT_EN
        ,
        .pixel_count (pixel_count)
`endif
    );

    // Clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    int          n_cmp = 0;
    int          n_err = 0;
    logic [AW-1:0] exp_q[$];
    longint      exp_pix = 0;
    int          last_swap_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: list every framebuffer address the command must write, in row-major order.
    task automatic model_rect(input fb_op_t op, input int x, input int y, input int w, input int h);
        int xs, ys, xe, ye;
        exp_q.delete();
        if (op == OP_CLEAR) begin
            xs = 0; ys = 0; xe = W; ye = H;
        end else if (op == OP_FILL && w != 0 && h != 0 && x < W && y < H) begin
            xs = x; ys = y;
            xe = (x + w < W) ? x + w : W;
            ye = (y + h < H) ? y + h : H;
        end else begin
            return;
        end
        for (int yy = ys; yy < ye; yy++)
            for (int xx = xs; xx < xe; xx++)
                exp_q.push_back(AW'(yy * W + xx));
    endtask

    task automatic drive_junk();
        cmd_valid = 1'b1;
        cmd_op    = fb_op_t'($urandom_range(0, 3));
        cmd_x     = 9'($urandom);
        cmd_y     = 8'($urandom);
        cmd_w     = 9'($urandom);
        cmd_h     = 8'($urandom);
        cmd_color = 16'($urandom);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_we"}, bus.write_enable, 1'b0);
        chk({tag, "_swap"}, bus.swap_buffer, 1'b0);
        chk({tag, "_ready"}, cmd_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
`ifdef FB_WRITER_PIXEL_COUNT_EN
        chk({tag, "_pixcnt"}, pixel_count, 32'(exp_pix));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_pix = 0;
        exp_q.delete();
        chk_idle("rst");
        chk("rst_addr", bus.write_addr, '0);
        chk("rst_data", bus.write_data, '0);
        chk("rst_state", state_dbg, ST_IDLE);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where cmd_ready is back.
    task automatic do_cmd(input fb_op_t op, input int x, input int y, input int w, input int h,
                          input logic [15:0] color, input int abort_at);
        int n;
        logic [AW-1:0] a;
        chk("pre_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = 9'(x);
        cmd_y     = 8'(y);
        cmd_w     = 9'(w);
        cmd_h     = 8'(h);
        cmd_color = color;
        model_rect(op, x, y, w, h);
        @(posedge clk);
        @(negedge clk);
        if (op == OP_SWAP) begin
            last_swap_cyc = cyc;
            chk("swap_pulse", bus.swap_buffer, 1'b1);
            chk("swap_we", bus.write_enable, 1'b0);
            chk("swap_ready", cmd_ready, 1'b0);
            drive_junk();
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
            chk_idle("swap_end");
            return;
        end
        n = exp_q.size();
        for (int k = 1; k <= n; k++) begin
            a = exp_q.pop_front();
            chk("wr_en", bus.write_enable, 1'b1);
            chk("wr_addr", bus.write_addr, a);
            chk("wr_data", bus.write_data, color);
            chk("wr_swap", bus.swap_buffer, 1'b0);
            chk("wr_busy", busy, 1'b1);
            exp_pix++;
            drive_junk();
            if (k == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                cmd_valid = 1'b0;
                exp_pix = 0;
                exp_q.delete();
                chk_idle("abort");
                chk("abort_state", state_dbg, ST_IDLE);
                return;
            end
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk_idle("done");
    endtask

    initial begin
        int p1;
        int r;
        // Reset phase
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_idle("init");
        chk("init_addr", bus.write_addr, '0);
        chk("init_data", bus.write_data, '0);
        chk("init_state", state_dbg, ST_IDLE);
        chk("write_clk", bus.write_clk, clk);

        // Directed corner cases
        do_cmd(OP_FILL, 2, 1, 3, 2, 16'hF800, 0);
        do_cmd(OP_FILL, 318, 179, 10, 10, 16'h07E0, 0);
        do_cmd(OP_FILL, 5, 5, 0, 4, 16'h1234, 0);
        do_cmd(OP_FILL, 400, 5, 4, 4, 16'h1234, 0);
        do_cmd(OP_FILL, 5, 200, 4, 4, 16'h1234, 0);
        do_cmd(OP_NOP, 1, 1, 4, 4, 16'hABCD, 0);
        do_cmd(OP_SWAP, 0, 0, 0, 0, 16'h0000, 0);
        p1 = last_swap_cyc;
        do_cmd(OP_SWAP, 0, 0, 0, 0, 16'h0000, 0);
        chk("swap_gap", 32'(last_swap_cyc - p1), 32'd2);

        // Abort a clear at its 100th write, then confirm a normal fill still works
        do_cmd(OP_CLEAR, 0, 0, 0, 0, 16'h001F, 100);
        do_cmd(OP_FILL, 10, 20, 4, 3, 16'hBEEF, 0);

        // Full clear from a fresh reset
        do_reset();
        do_cmd(OP_CLEAR, 7, 7, 3, 3, 16'h001F, 0);

        // Randomized commands
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 6)
                do_cmd(OP_FILL, $urandom_range(0, 340), $urandom_range(0, 190),
                       $urandom_range(0, 32), $urandom_range(0, 8), 16'($urandom), 0);
            else if (r == 7)
                do_cmd(OP_SWAP, $urandom_range(0, 511), $urandom_range(0, 255),
                       $urandom_range(0, 511), $urandom_range(0, 255), 16'($urandom), 0);
            else if (r == 8)
                do_cmd(OP_NOP, $urandom_range(0, 100), $urandom_range(0, 100),
                       $urandom_range(0, 20), $urandom_range(0, 20), 16'($urandom), 0);
            else
                do_cmd(OP_FILL, $urandom_range(300, 319), $urandom_range(170, 179),
                       $urandom_range(1, 511), $urandom_range(1, 255), 16'($urandom), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
